tx_frame_sequencer: RTL and testbench

TX_FRAME_SEQUENCER -- requirements
Module: tx_frame_sequencer

---
 rtl/tx_seq_pkg.sv | 26 ++
 rtl/tx_seq_timeout.sv | 31 +++
 rtl/tx_frame_sequencer.sv | 152 +++++++++++++++
 tb/tb_tx_frame_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_seq_pkg.sv
// rtl/tx_seq_pkg.sv - shared state encodings, widths and error causes for tx_frame_sequencer
package tx_seq_pkg;

    localparam int SIZE_W = 16;

    typedef enum logic [1:0] {
        S_SIZE0 = 2'd0,
        S_SIZE1 = 2'd1,
        S_DATA  = 2'd2,
        S_DROP  = 2'd3
    } tx_seq_state_t;

    // Error-cause codes, also decoded by the io_module status registers
    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_SIZE_ZERO  = 3'd1;
    localparam logic [2:0] ERR_SIZE_MAX   = 3'd2;
    localparam logic [2:0] ERR_NO_SPACE   = 3'd3;
    localparam logic [2:0] ERR_QUEUE_FULL = 3'd4;
    localparam logic [2:0] ERR_NOT_READY  = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT    = 3'd6;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/tx_seq_timeout.sv
// rtl/tx_seq_timeout.sv - inter-byte idle timer for tx_frame_sequencer (built under TX_SEQ_TIMEOUT_EN)
module tx_seq_timeout
    import tx_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic active,
    input  logic strobe,
    output logic expired
);

    localparam logic [SIZE_W-1:0] LIMIT = SIZE_W'(TIMEOUT_CYCLES - 1);

    logic [SIZE_W-1:0] idle_count;

    // Fires on the TIMEOUT_CYCLES-th consecutive idle clock of an open frame
    assign expired = active && !strobe && (idle_count == LIMIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idle_count <= '0;
        end else if (!active || strobe || expired) begin
            idle_count <= '0;
        end else begin
            idle_count <= idle_count + 1'b1;
        end
    end

endmodule

// File: rtl/tx_frame_sequencer.sv
// rtl/tx_frame_sequencer.sv - size-prefixed byte stream to transmitter frame sequencer; optional idle abort under TX_SEQ_TIMEOUT_EN
module tx_frame_sequencer
    import tx_seq_pkg::*;
#(
    parameter int MAX_FRAME_SIZE = 1024,
    parameter int MAX_FRAMES     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_byte_stb,
    input  logic [7:0]        i_byte,
    input  logic [SIZE_W-1:0] i_tx_free,
    input  logic [7:0]        i_tx_frames_count,
    output logic              o_ready,
    output logic              o_tx_push_write_index,
    output logic              o_tx_pop_write_index,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_data_we,
    output logic              o_tx_push_frame,
    output logic [7:0]        o_err_count,
    output logic [1:0]        o_state
);

    localparam logic [SIZE_W-1:0] MAX_SIZE_V   = SIZE_W'(MAX_FRAME_SIZE);
    localparam logic [SIZE_W-1:0] MAX_FRAMES_V = SIZE_W'(MAX_FRAMES);

    tx_seq_state_t     state, state_nxt;
    logic [SIZE_W-1:0] counter, counter_nxt;
    logic [7:0]        size_lo, size_lo_nxt;
    logic              commit, commit_nxt;
    logic [7:0]        data_nxt;
    logic              we_nxt, push_wi_nxt, pop_wi_nxt, push_frame_nxt;
    logic [2:0]        err_cause;
    logic [SIZE_W-1:0] size_full;
    logic              timeout_hit;

`ifdef TX_SEQ_TIMEOUT_EN
    tx_seq_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .active  (state != S_SIZE0),
        .strobe  (i_byte_stb),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    assign size_full = {i_byte, size_lo};
    assign o_ready   = i_rst_n && i_en && !commit;
    assign o_state   = state;

    always_comb begin
        state_nxt      = state;
        counter_nxt    = counter;
        size_lo_nxt    = size_lo;
        commit_nxt     = 1'b0;
        data_nxt       = o_tx_data;
        we_nxt         = 1'b0;
        push_wi_nxt    = 1'b0;
        pop_wi_nxt     = 1'b0;
        push_frame_nxt = 1'b0;
        err_cause      = ERR_NONE;

        if (!i_en || timeout_hit) begin
            // Abort: only an open S_DATA frame has written bytes to roll back
            state_nxt  = S_SIZE0;
            pop_wi_nxt = (state == S_DATA);
            if (i_en) begin
                err_cause = ERR_TIMEOUT;
            end
        end else if (commit) begin
            push_frame_nxt = 1'b1;
            state_nxt      = S_SIZE0;
            if (i_byte_stb) begin
                err_cause = ERR_NOT_READY;
            end
        end else if (i_byte_stb) begin
            case (state)
                S_SIZE0: begin
                    size_lo_nxt = i_byte;
                    state_nxt   = S_SIZE1;
                end
                S_SIZE1: begin
                    counter_nxt = size_full;
                    if (size_full == '0) begin
                        err_cause = ERR_SIZE_ZERO;
                        state_nxt = S_SIZE0;
                    end else if (size_full > MAX_SIZE_V) begin
                        err_cause = ERR_SIZE_MAX;
                        state_nxt = S_DROP;
                    end else if (size_full > i_tx_free) begin
                        err_cause = ERR_NO_SPACE;
                        state_nxt = S_DROP;
                    end else if ({8'd0, i_tx_frames_count} >= MAX_FRAMES_V) begin
                        err_cause = ERR_QUEUE_FULL;
                        state_nxt = S_DROP;
                    end else begin
                        push_wi_nxt = 1'b1;
                        state_nxt   = S_DATA;
                    end
                end
                S_DATA: begin
                    data_nxt    = i_byte;
                    we_nxt      = 1'b1;
                    counter_nxt = counter - 1'b1;
                    commit_nxt  = (counter == SIZE_W'(1));
                end
                S_DROP: begin
                    counter_nxt = counter - 1'b1;
                    if (counter == SIZE_W'(1)) begin
                        state_nxt = S_SIZE0;
                    end
                end
                default: state_nxt = S_SIZE0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state                 <= S_SIZE0;
            counter               <= '0;
            size_lo               <= '0;
            commit                <= 1'b0;
            o_tx_data             <= '0;
            o_tx_data_we          <= 1'b0;
            o_tx_push_write_index <= 1'b0;
            o_tx_pop_write_index  <= 1'b0;
            o_tx_push_frame       <= 1'b0;
            o_err_count           <= '0;
        end else begin
            state                 <= state_nxt;
            counter               <= counter_nxt;
            size_lo               <= size_lo_nxt;
            commit                <= commit_nxt;
            o_tx_data             <= data_nxt;
            o_tx_data_we          <= we_nxt;
            o_tx_push_write_index <= push_wi_nxt;
            o_tx_pop_write_index  <= pop_wi_nxt;
            o_tx_push_frame       <= push_frame_nxt;
            if (err_cause != ERR_NONE) begin
                o_err_count <= sat_inc8(o_err_count);
            end
        end
    end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// tb/tb_tx_frame_sequencer.sv - directed vector bench for tx_frame_sequencer
module tb_tx_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        stb = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic [15:0] free = 16'd100;
    logic [7:0]  frames = 8'd0;
    logic        ready, push_wi, pop_wi, we, push_frame;
    logic [7:0]  data, err;
    logic [1:0]  state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tx_frame_sequencer #(
        .MAX_FRAME_SIZE(1024),
        .MAX_FRAMES(16),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_en                  (en),
        .i_byte_stb            (stb),
        .i_byte                (byte_in),
        .i_tx_free             (free),
        .i_tx_frames_count     (frames),
        .o_ready               (ready),
        .o_tx_push_write_index (push_wi),
        .o_tx_pop_write_index  (pop_wi),
        .o_tx_data             (data),
        .o_tx_data_we          (we),
        .o_tx_push_frame       (push_frame),
        .o_err_count           (err),
        .o_state               (state)
    );

    typedef struct {
        logic        en;
        logic        stb;
        logic [7:0]  b;
        logic [15:0] free;
        logic [7:0]  frames;
        logic        rdy;
        logic        we;
        logic [7:0]  data;
        logic        pwi;
        logic        pop;
        logic        pf;
        logic [1:0]  st;
        logic [7:0]  err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic e, input logic s, input logic [7:0] b, input logic [15:0] f,
                                input logic [7:0] fr, input logic r, input logic w, input logic [7:0] d,
                                input logic pwi_e, input logic pop_e, input logic pf_e, input logic [1:0] st_e,
                                input logic [7:0] err_e);
        vec_t v;
        v.en = e; v.stb = s; v.b = b; v.free = f; v.frames = fr;
        v.rdy = r; v.we = w; v.data = d; v.pwi = pwi_e; v.pop = pop_e; v.pf = pf_e; v.st = st_e; v.err = err_e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic s, input logic [7:0] b);
        en = e; stb = s; byte_in = b;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] outs();
        return {ready, we, push_wi, pop_wi, push_frame, state, err};
    endfunction

    initial begin
        logic [7:0] exp_err;
        logic       bad;
        bit         seen;
        int         idle;

        // name: en stb byte free frames | rdy we data pwi pop pf st err
        vecs.push_back(mk(1,1,8'h03,100,0, 1,0,8'h00,0,0,0,2'd1,0));
        vecs.push_back(mk(1,1,8'h00,100,0, 1,0,8'h00,1,0,0,2'd2,0));
        vecs.push_back(mk(1,1,8'hAA,100,0, 1,1,8'hAA,0,0,0,2'd2,0));
        vecs.push_back(mk(1,1,8'hBB,100,0, 1,1,8'hBB,0,0,0,2'd2,0));
        vecs.push_back(mk(1,1,8'hCC,100,0, 0,1,8'hCC,0,0,0,2'd2,0));
        vecs.push_back(mk(1,0,8'h00,100,0, 1,0,8'h00,0,0,1,2'd0,0));
        vecs.push_back(mk(1,0,8'h00,100,0, 1,0,8'h00,0,0,0,2'd0,0));
        // zero-size frame
        vecs.push_back(mk(1,1,8'h00,100,0, 1,0,8'h00,0,0,0,2'd1,0));
        vecs.push_back(mk(1,1,8'h00,100,0, 1,0,8'h00,0,0,0,2'd0,1));
        // queue full -> drop 4 bytes, then a 1-byte frame commits
        vecs.push_back(mk(1,1,8'h04,100,16, 1,0,8'h00,0,0,0,2'd1,1));
        vecs.push_back(mk(1,1,8'h00,100,16, 1,0,8'h00,0,0,0,2'd3,2));
        vecs.push_back(mk(1,1,8'h10,100,16, 1,0,8'h00,0,0,0,2'd3,2));
        vecs.push_back(mk(1,1,8'h11,100,16, 1,0,8'h00,0,0,0,2'd3,2));
        vecs.push_back(mk(1,1,8'h12,100,16, 1,0,8'h00,0,0,0,2'd3,2));
        vecs.push_back(mk(1,1,8'h13,100,16, 1,0,8'h00,0,0,0,2'd0,2));
        vecs.push_back(mk(1,1,8'h01,100,0, 1,0,8'h00,0,0,0,2'd1,2));
        vecs.push_back(mk(1,1,8'h00,100,0, 1,0,8'h00,1,0,0,2'd2,2));
        vecs.push_back(mk(1,1,8'h5A,100,0, 0,1,8'h5A,0,0,0,2'd2,2));
        vecs.push_back(mk(1,0,8'h00,100,0, 1,0,8'h00,0,0,1,2'd0,2));
        // size larger than free space -> drop
        vecs.push_back(mk(1,1,8'h03,2,0, 1,0,8'h00,0,0,0,2'd1,2));
        vecs.push_back(mk(1,1,8'h00,2,0, 1,0,8'h00,0,0,0,2'd3,3));
        vecs.push_back(mk(1,1,8'h21,2,0, 1,0,8'h00,0,0,0,2'd3,3));
        vecs.push_back(mk(1,1,8'h22,2,0, 1,0,8'h00,0,0,0,2'd3,3));
        vecs.push_back(mk(1,1,8'h23,2,0, 1,0,8'h00,0,0,0,2'd0,3));
        // enable drop coincident with third payload strobe
        vecs.push_back(mk(1,1,8'h04,100,0, 1,0,8'h00,0,0,0,2'd1,3));
        vecs.push_back(mk(1,1,8'h00,100,0, 1,0,8'h00,1,0,0,2'd2,3));
        vecs.push_back(mk(1,1,8'h11,100,0, 1,1,8'h11,0,0,0,2'd2,3));
        vecs.push_back(mk(1,1,8'h22,100,0, 1,1,8'h22,0,0,0,2'd2,3));
        vecs.push_back(mk(0,1,8'h33,100,0, 0,0,8'h00,0,1,0,2'd0,3));
        vecs.push_back(mk(1,0,8'h00,100,0, 1,0,8'h00,0,0,0,2'd0,3));
        // enable drop in S_SIZE1 is silent
        vecs.push_back(mk(1,1,8'h05,100,0, 1,0,8'h00,0,0,0,2'd1,3));
        vecs.push_back(mk(0,0,8'h00,100,0, 0,0,8'h00,0,0,0,2'd0,3));
        vecs.push_back(mk(1,0,8'h00,100,0, 1,0,8'h00,0,0,0,2'd0,3));
        // strobe during commit cycle is ignored and counted
        vecs.push_back(mk(1,1,8'h01,100,0, 1,0,8'h00,0,0,0,2'd1,3));
        vecs.push_back(mk(1,1,8'h00,100,0, 1,0,8'h00,1,0,0,2'd2,3));
        vecs.push_back(mk(1,1,8'h77,100,0, 0,1,8'h77,0,0,0,2'd2,3));
        vecs.push_back(mk(1,1,8'h99,100,0, 1,0,8'h00,0,0,1,2'd0,4));
        vecs.push_back(mk(1,0,8'h00,100,0, 1,0,8'h00,0,0,0,2'd0,4));
        // size == MAX_FRAME_SIZE and frames == MAX_FRAMES-1 accepted
        vecs.push_back(mk(1,1,8'h00,2000,15, 1,0,8'h00,0,0,0,2'd1,4));
        vecs.push_back(mk(1,1,8'h04,2000,15, 1,0,8'h00,1,0,0,2'd2,4));
        vecs.push_back(mk(0,0,8'h00,2000,15, 0,0,8'h00,0,1,0,2'd0,4));
        vecs.push_back(mk(1,0,8'h00,100,0, 1,0,8'h00,0,0,0,2'd0,4));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(outs()), 32'd0);
        chk("reset_data", 32'(data), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            free = vecs[i].free;
            frames = vecs[i].frames;
            step(vecs[i].en, vecs[i].stb, vecs[i].b);
            chk($sformatf("vec%0d_outs", i), 32'(outs()),
                32'({vecs[i].rdy, vecs[i].we, vecs[i].pwi, vecs[i].pop, vecs[i].pf, vecs[i].st, vecs[i].err}));
            if (vecs[i].we) chk($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].data));
        end
        exp_err = 8'd4;
        free = 16'd100;
        frames = 8'd0;

`ifdef TX_SEQ_TIMEOUT_EN
        step(1, 1, 8'h02);
        step(1, 1, 8'h00);
        step(1, 1, 8'h44);
        seen = 0;
        idle = 0;
        while (!seen && idle < 20) begin
            step(1, 0, 8'h00);
            idle++;
            if (pop_wi) seen = 1;
        end
        exp_err = exp_err + 8'd1;
        chk("timeout_pop_seen", 32'(seen), 32'd1);
        chk("timeout_idle_clocks", 32'(idle), 32'd10);
        chk("timeout_err_state", 32'({state, err}), 32'({2'd0, exp_err}));
`endif

        // oversize frame dropped byte by byte with no transmitter activity
        step(1, 1, 8'h00);
        step(1, 1, 8'h05);
        exp_err = exp_err + 8'd1;
        chk("oversize_drop_state", 32'({state, err}), 32'({2'd3, exp_err}));
        bad = 1'b0;
        for (int i = 0; i < 1280; i++) begin
            step(1, 1, 8'(i));
            bad = bad | we | push_wi | push_frame | pop_wi;
            if (i == 1278) chk("oversize_state_before_last", 32'(state), 32'd3);
        end
        chk("oversize_no_pulses", 32'(bad), 32'd0);
        chk("oversize_end_state", 32'({state, err}), 32'({2'd0, exp_err}));

        // 300 zero-size frames saturate the error counter
        for (int i = 0; i < 300; i++) begin
            step(1, 1, 8'h00);
            step(1, 1, 8'h00);
        end
        chk("err_saturated", 32'(err), 32'd255);
        step(1, 1, 8'h00);
        step(1, 1, 8'h00);
        chk("err_holds_255", 32'(err), 32'd255);

        // asynchronous reset mid-frame: no pop pulse, everything cleared
        step(1, 1, 8'h02);
        step(1, 1, 8'h00);
        chk("pre_reset_data_state", 32'(state), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(outs()), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 0, 8'h00);
        chk("post_reset_idle", 32'(outs()), 32'({1'b1, 14'd0}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
